// File: rtl/jtdsp16_pkg.sv
// Shared DSP16 definitions: cache FSM encoding, sizes and do/redo field positions.
package jtdsp16_pkg;
  localparam int DW    = 16;
  localparam int DEPTH = 15;
  localparam int KW    = 7;

  // do/redo instruction fields as seen by the decoder
  localparam int K_LSB  = 0;
  localparam int K_MSB  = K_LSB + KW - 1;
  localparam int NI_LSB = 7;
  localparam int NI_MSB = NI_LSB + 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_LOOP = 2'd2
  } cache_st_t;
endpackage

// File: rtl/jtdsp16_cache_if.sv
// Decoder/ROM side bus of the instruction cache.
interface jtdsp16_cache_if #(
  parameter int DW = 16,
  parameter int KW = 7
);
  logic          cen;
  logic          do_en;
  logic [3:0]    do_ni;
  logic [KW-1:0] do_k;
  logic          redo_en;
  logic [KW-1:0] redo_k;
  logic          inst_adv;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] cache_data;
  logic          cache_sel;
  logic          pc_halt;
  logic          loop_done;

  modport master (
    output cen, do_en, do_ni, do_k, redo_en, redo_k, inst_adv, rom_data,
    input  cache_data, cache_sel, pc_halt, loop_done
  );
  modport slave (
    input  cen, do_en, do_ni, do_k, redo_en, redo_k, inst_adv, rom_data,
    output cache_data, cache_sel, pc_halt, loop_done
  );
endinterface

// File: rtl/jtdsp16_cache_mem.sv
// Loop body register file: one synchronous write port, one combinational read port.
module jtdsp16_cache_mem #(
  parameter int DW    = 16,
  parameter int DEPTH = 15
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [3:0]    raddr,
  output logic [DW-1:0] rdata
);
  localparam logic [3:0] LAST = 4'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];

  // contents are deliberately not reset so a redo after loop_done can replay them
  always_ff @(posedge clk)
    if (cen && we && waddr <= LAST) mem[waddr] <= wdata;

  assign rdata = (raddr <= LAST) ? mem[raddr] : '0;
endmodule

// File: rtl/jtdsp16_cache.sv
// DSP16 instruction cache / hardware loop controller for do K {NI} and redo K.
module jtdsp16_cache
  import jtdsp16_pkg::*;
#(
  parameter int DW    = jtdsp16_pkg::DW,
  parameter int DEPTH = jtdsp16_pkg::DEPTH,
  parameter int KW    = jtdsp16_pkg::KW
) (
  input  logic            clk,
  input  logic            rst,
  jtdsp16_cache_if.slave  bus
);
  cache_st_t     st;
  logic [3:0]    ni, ptr;
  logic [KW-1:0] cnt;
  logic          valid;
  logic          sel_r, halt_r, done_r;

  logic adv, last, cnt_one, do_ok, redo_ok, we;

  // an inst_adv coincident with do/redo consumes the do/redo word itself
  assign adv     = bus.inst_adv & ~bus.do_en & ~bus.redo_en;
  assign last    = ptr == ni - 4'd1;
  assign cnt_one = cnt == KW'(1);
  assign do_ok   = bus.do_en && bus.do_ni != 4'd0 && bus.do_ni <= 4'(DEPTH)
                   && bus.do_k != '0;
  assign redo_ok = bus.redo_en && valid && bus.redo_k != '0;
  assign we      = st == ST_FILL && adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= ST_IDLE;
      ni     <= '0;
      cnt    <= '0;
      ptr    <= '0;
      valid  <= 1'b0;
      sel_r  <= 1'b0;
      halt_r <= 1'b0;
      done_r <= 1'b0;
    end else if (bus.cen) begin
      done_r <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (do_ok) begin
            ni    <= bus.do_ni;
            cnt   <= bus.do_k;
            ptr   <= '0;
            valid <= 1'b0;
            st    <= ST_FILL;
          end else if (redo_ok) begin
            cnt    <= bus.redo_k;
            ptr    <= '0;
            st     <= ST_LOOP;
            sel_r  <= 1'b1;
            halt_r <= 1'b1;
          end
        end
        ST_FILL: if (adv) begin
          if (!last) ptr <= ptr + 4'd1;
          else begin
            valid <= 1'b1;
            ptr   <= '0;
            if (cnt_one) begin
              done_r <= 1'b1;
              st     <= ST_IDLE;
            end else begin
              cnt    <= cnt - KW'(1);
              st     <= ST_LOOP;
              sel_r  <= 1'b1;
              halt_r <= 1'b1;
            end
          end
        end
        ST_LOOP: if (adv) begin
          if (!last) ptr <= ptr + 4'd1;
          else if (cnt_one) begin
            done_r <= 1'b1;
            ptr    <= '0;
            st     <= ST_IDLE;
            sel_r  <= 1'b0;
            halt_r <= 1'b0;
          end else begin
            cnt <= cnt - KW'(1);
            ptr <= '0;
          end
        end
        default: begin
          st     <= ST_IDLE;
          sel_r  <= 1'b0;
          halt_r <= 1'b0;
        end
      endcase
    end
  end

  jtdsp16_cache_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .cen   (bus.cen),
    .we    (we),
    .waddr (ptr),
    .wdata (bus.rom_data),
    .raddr (ptr),
    .rdata (bus.cache_data)
  );

  assign bus.cache_sel = sel_r;
  assign bus.pc_halt   = halt_r;
  assign bus.loop_done = done_r;
endmodule

// File: tb/tb_jtdsp16_cache.sv
// Randomized bench for jtdsp16_cache against a pass/position-count loop model.
module tb_jtdsp16_cache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jtdsp16_cache_if #(.DW(16), .KW(7)) bus();

  jtdsp16_cache dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  // model: an active block is total=NI*K consumed words; the first 'fill' come from ROM
  bit          m_act, m_valid, m_ld;
  int          m_fill, m_total, m_pos, m_ni;
  logic [15:0] m_mem [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_sel();
    return m_act && m_pos >= m_fill;
  endfunction

  task automatic check_out();
    chk("sel",  {31'd0, bus.cache_sel}, {31'd0, m_sel()});
    chk("halt", {31'd0, bus.pc_halt},   {31'd0, m_sel()});
    chk("done", {31'd0, bus.loop_done}, {31'd0, m_ld});
    if (m_sel()) chk("data", {16'd0, bus.cache_data}, {16'd0, m_mem[m_pos % m_ni]});
  endtask

  task automatic model_step();
    bit adv;
    if (!bus.cen) return;
    m_ld = 0;
    adv = bus.inst_adv && !bus.do_en && !bus.redo_en;
    if (!m_act) begin
      if (bus.do_en && bus.do_ni != 0 && bus.do_k != 0) begin
        m_act = 1; m_fill = int'(bus.do_ni); m_ni = int'(bus.do_ni);
        m_total = m_ni * int'(bus.do_k); m_pos = 0; m_valid = 0;
      end else if (bus.redo_en && m_valid && bus.redo_k != 0) begin
        m_act = 1; m_fill = 0; m_total = m_ni * int'(bus.redo_k); m_pos = 0;
      end
    end else if (adv) begin
      if (m_pos < m_fill) begin
        m_mem[m_pos] = bus.rom_data;
        if (m_pos == m_fill - 1) m_valid = 1;
      end
      m_pos++;
      if (m_pos == m_total) begin m_act = 0; m_ld = 1; end
    end
  endtask

  task automatic tick(input bit c, input bit a, input bit de, input logic [3:0] dni,
                      input logic [6:0] dk, input bit re, input logic [6:0] rk);
    @(negedge clk);
    check_out();
    bus.cen = c; bus.inst_adv = a; bus.do_en = de; bus.do_ni = dni; bus.do_k = dk;
    bus.redo_en = re; bus.redo_k = rk; bus.rom_data = 16'($urandom);
    @(posedge clk);
    model_step();
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    m_act = 0; m_valid = 0; m_ld = 0;
    #1 check_out();
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'($urandom_range(1)), 1'b0, 4'd0, 7'd0, 1'b0, 7'd0);
  endtask

  // run until the active block finishes; stray do/redo are sprinkled in to be ignored
  task automatic drain(input int pa, input int pc);
    int b = 0;
    while (m_act && b < 3000) begin
      if ($urandom_range(99) < 4)
        tick(1'b1, 1'($urandom_range(1)), 1'b1, 4'($urandom_range(1, 15)),
             7'($urandom_range(1, 9)), 1'b0, 7'd0);
      else
        tick(1'($urandom_range(99) < pc), 1'($urandom_range(99) < pa),
             1'b0, 4'd0, 7'd0, 1'b0, 7'd0);
      b++;
    end
    chk("timeout", {31'd0, m_act}, 32'd0);
    idle(3);
  endtask

  task automatic issue_do(input int ni, input int k, input bit a);
    tick(1'b1, a, 1'b1, 4'(ni), 7'(k), 1'b0, 7'd0);
  endtask

  task automatic issue_redo(input int k, input bit a);
    tick(1'b1, a, 1'b0, 4'd0, 7'd0, 1'b1, 7'(k));
  endtask

  initial begin
    bus.cen = 1'b1; bus.inst_adv = 1'b0; bus.do_en = 1'b0; bus.do_ni = '0; bus.do_k = '0;
    bus.redo_en = 1'b0; bus.redo_k = '0; bus.rom_data = '0;
    m_act = 0; m_valid = 0; m_ld = 0; m_fill = 0; m_total = 0; m_pos = 0; m_ni = 0;
    pulse_rst();
    idle(2);

    // do NI=3 K=4, coincident inst_adv is not captured
    issue_do(3, 4, 1'b1);
    drain(100, 100);

    // do NI=15 K=1 never loops, then redo K=2 replays from cache
    issue_do(15, 1, 1'b0);
    drain(70, 80);
    issue_redo(2, 1'b1);
    drain(70, 80);

    // reset clears valid: redo and malformed do are ignored
    pulse_rst();
    issue_redo(5, 1'b0);
    idle(3);
    issue_do(0, 5, 1'b1);
    idle(2);
    issue_do(4, 0, 1'b1);
    idle(3);

    // NI=2 K=3 with cen and inst_adv randomly low
    issue_do(2, 3, 1'b0);
    drain(50, 50);

    // do_en during LOOP is ignored
    issue_do(3, 4, 1'b0);
    while (m_act && !m_sel()) tick(1'b1, 1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 7'd0);
    tick(1'b1, 1'b0, 1'b1, 4'd5, 7'd2, 1'b0, 7'd0);
    drain(60, 70);

    // reset in iteration 2 of 4, then redo must be ignored
    issue_do(3, 4, 1'b0);
    while (m_act && m_pos < 7) tick(1'b1, 1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 7'd0);
    pulse_rst();
    idle(2);
    issue_redo(2, 1'b0);
    idle(4);

    // random soak
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(2) == 0 && m_valid) issue_redo($urandom_range(0, 4), 1'($urandom_range(1)));
      else issue_do($urandom_range(0, 15), $urandom_range(0, 4), 1'($urandom_range(1)));
      drain($urandom_range(30, 100), $urandom_range(40, 100));
    end

    @(negedge clk);
    check_out();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
